intr_ctrl: RTL and testbench
============================

# intr_ctrl

Priority interrupt controller for the pipelined 16-bit processor. It edge-detects and latches interrupt requests from the timer, key and switch devices, applies a memory-mapped mask, and presents one prioritized request with its number to the pipeline. It tracks the request through acknowledge, in-service and RETI. Its PEND and MASK registers are memory-mapped on the shared ABUS/RBUS/WBUS device bus.

## Interface
Parameters:
- ABITS, 16, address bus width
- DBITS, 16, data bus width
- PADDR, 16'hFFE8, address of PEND register
- MADDR, 16'hFFEA, address of MASK register

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- INIT_N  in  1  reset, asynchronous, active-low
- ABUS  in  ABITS  memory-stage address
- RBUS  inout (tri)  DBITS  read bus; driven only on a register hit, else z
- RE  in  1  bus read enable
- WBUS  in  DBITS  bus write data
- WE  in  1  bus write enable
- IRQ  in  3  device interrupt levels: [0] timer, [1] keys, [2] switches
- IE  in  1  processor SCS.IE
- INTACK  in  1  one-cycle pulse: the pipeline has taken the request (flush, SRA/SII saved)
- RETI  in  1  one-cycle pulse: RETI has committed
- INTREQ  out  1  request to the pipeline
- INTNUM  out  4  number of the requested source: 1 timer, 2 keys, 3 switches, 4'hF none
- INSVC  out  1  a handler is in service

## Operation
- Edge detect: IRQ_q holds the previous IRQ. A rising edge (IRQ & ~IRQ_q) sets the matching PEND bit.
- PEND[2:0] read: RE && ABUS==PADDR drives {13'b0,PEND} on RBUS.
- PEND write: WE && ABUS==PADDR clears each bit where WBUS bit=1 (write-1-to-clear).
- MASK[2:0] read/write at MADDR: read {13'b0,MASK}; write MASK<=WBUS[2:0]. A 1 enables the source.
- eligible = PEND & MASK. Priority: timer > keys > switches.
- State machine:
  - IDLE: when IE && eligible!=0, go to REQ; latch INTNUM from the highest-priority eligible bit.
  - REQ: INTREQ=1; INTNUM held stable.
    - On INTACK: clear that PEND bit and go to INSVC.
    - Else, if IE==0 or the latched bit is no longer eligible (masked or cleared by a write): withdraw to IDLE with INTNUM=4'hF. PEND is kept.
  - INSVC: INSVC=1, INTREQ=0. No new request is raised even if IE is re-enabled (no nesting). On RETI, go to IDLE.
- Simultaneous events:
  - Set and clear of the same PEND bit in one cycle (edge vs INTACK clear, or edge vs write-1-clear): the set wins.
  - INTACK and a withdraw condition in the same cycle: INTACK wins.
  - RETI outside INSVC and INTACK outside REQ are ignored.
- Reset (INIT_N=0, any time, including mid-handshake):
  - State=IDLE, PEND=0, IRQ_q=0, MASK=3'b111.
  - INTREQ=0, INTNUM=4'hF, INSVC=0, RBUS=z.

## Timing
- IRQ rises at edge n: PEND is set at edge n+1.
- INTREQ and INTNUM are registered: both are valid after edge n+2 when IE=1. Total latency from the IRQ edge is 2 cycles.
- INTREQ stays high until the INTACK edge; INTREQ=0 and INSVC=1 after that edge.
- RETI sampled at an edge: INSVC=0 after that edge. A pending eligible source raises INTREQ one edge later, i.e. at least 1 idle cycle between handlers.
- Bus reads are combinational in the same cycle as RE/ABUS. Writes take effect at the next edge.
- INTNUM is 4'hF whenever INTREQ=0.

## Test plan
- Reset/regs: after INIT_N release, read MADDR -> 16'h0007, PADDR -> 16'h0000, INTREQ=0, INTNUM=4'hF.
- Single request: IE=1, raise IRQ[1] -> INTREQ=1 with INTNUM=2 two cycles later. Pulse INTACK -> INTREQ=0, INSVC=1, PEND=0. Pulse RETI -> INSVC=0.
- Priority: raise IRQ[2] and IRQ[0] in the same cycle -> INTNUM=1. After INTACK and RETI -> INTNUM=3, one idle cycle later.
- Mask/withdraw:
  - With MASK=3'b110, raise IRQ[0] -> no request; PEND reads 16'h0001.
  - Write MASK=3'b111 -> request with INTNUM=1.
  - Drop IE during REQ -> INTREQ=0 next cycle; PEND still 1.
- Collisions:
  - Write-1-clear PEND[1] in the same cycle as a new IRQ[1] edge -> PEND[1] stays 1.
  - RETI pulse while IDLE -> no effect.
  - IRQ held high -> only one PEND set.
- Async reset while in REQ -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - priority interrupt controller with memory-mapped PEND/MASK
// Latches device IRQ edges, masks and prioritizes them, and tracks request/ack/in-service/RETI.
module intr_ctrl #(
  parameter int              ABITS = 16,
  parameter int              DBITS = 16,
  parameter logic [ABITS-1:0] PADDR = 16'hFFE8,
  parameter logic [ABITS-1:0] MADDR = 16'hFFEA
) (
  input  logic             CLK,
  input  logic             INIT_N,
  input  logic [ABITS-1:0] ABUS,
  inout  tri   [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  input  logic [2:0]       IRQ,
  input  logic             IE,
  input  logic             INTACK,
  input  logic             RETI,
  output logic             INTREQ,
  output logic [3:0]       INTNUM,
  output logic             INSVC
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_irq_q;
  logic [2:0] r_pend;
  logic [2:0] r_mask;
  logic [3:0] r_intnum, w_intnum_nxt;

  logic       w_p_hit, w_m_hit;
  logic [2:0] w_rise, w_eligible, w_wr_clr, w_ack_clr, w_cur_bit;
  logic [3:0] w_sel_num;
  logic       w_unused;

  assign w_p_hit    = (ABUS == PADDR);
  assign w_m_hit    = (ABUS == MADDR);
  assign w_rise     = IRQ & ~r_irq_q;
  assign w_eligible = r_pend & r_mask;
  assign w_wr_clr   = (WE && w_p_hit) ? WBUS[2:0] : 3'b000;
  assign w_unused   = ^WBUS[DBITS-1:3];

  assign RBUS = (RE && w_p_hit) ? {{(DBITS-3){1'b0}}, r_pend} :
                (RE && w_m_hit) ? {{(DBITS-3){1'b0}}, r_mask} :
                {DBITS{1'bz}};

  // Fixed priority: timer (1) over keys (2) over switches (3).
  always_comb begin
    w_sel_num = 4'hF;
    if (w_eligible[0])      w_sel_num = 4'd1;
    else if (w_eligible[1]) w_sel_num = 4'd2;
    else if (w_eligible[2]) w_sel_num = 4'd3;
  end

  always_comb begin
    w_cur_bit = 3'b000;
    case (r_intnum)
      4'd1:    w_cur_bit = 3'b001;
      4'd2:    w_cur_bit = 3'b010;
      4'd3:    w_cur_bit = 3'b100;
      default: w_cur_bit = 3'b000;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_intnum_nxt = r_intnum;
    w_ack_clr    = 3'b000;
    case (r_state)
      ST_IDLE: begin
        w_intnum_nxt = 4'hF;
        if (IE && (w_eligible != 3'b000)) begin
          w_state_nxt  = ST_REQ;
          w_intnum_nxt = w_sel_num;
        end
      end
      ST_REQ: begin
        if (INTACK) begin
          w_ack_clr    = w_cur_bit;
          w_state_nxt  = ST_INSVC;
          w_intnum_nxt = 4'hF;
        end else if (!IE || ((w_eligible & w_cur_bit) == 3'b000)) begin
          w_state_nxt  = ST_IDLE;
          w_intnum_nxt = 4'hF;
        end
      end
      ST_INSVC: begin
        w_intnum_nxt = 4'hF;
        if (RETI) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_intnum_nxt = 4'hF;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      r_state  <= ST_IDLE;
      r_irq_q  <= 3'b000;
      r_pend   <= 3'b000;
      r_mask   <= 3'b111;
      r_intnum <= 4'hF;
    end else begin
      r_state  <= w_state_nxt;
      r_irq_q  <= IRQ;
      // A new edge outranks any clear in the same cycle.
      r_pend   <= (r_pend & ~w_wr_clr & ~w_ack_clr) | w_rise;
      r_intnum <= w_intnum_nxt;
      if (WE && w_m_hit) r_mask <= WBUS[2:0];
    end
  end

  assign INTREQ = (r_state == ST_REQ);
  assign INSVC  = (r_state == ST_INSVC);
  assign INTNUM = r_intnum;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

  localparam logic [15:0] PADDR = 16'hFFE8;
  localparam logic [15:0] MADDR = 16'hFFEA;

  logic        CLK = 1'b0;
  logic        INIT_N;
  logic [15:0] ABUS;
  wire  [15:0] RBUS;
  logic        RE;
  logic [15:0] WBUS;
  logic        WE;
  logic [2:0]  IRQ;
  logic        IE;
  logic        INTACK;
  logic        RETI;
  logic        INTREQ;
  logic [3:0]  INTNUM;
  logic        INSVC;

  int checks = 0;
  int errors = 0;

  intr_ctrl dut (
    .CLK(CLK), .INIT_N(INIT_N), .ABUS(ABUS), .RBUS(RBUS), .RE(RE),
    .WBUS(WBUS), .WE(WE), .IRQ(IRQ), .IE(IE), .INTACK(INTACK), .RETI(RETI),
    .INTREQ(INTREQ), .INTNUM(INTNUM), .INSVC(INSVC)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    ABUS = addr;
    RE   = 1'b1;
    #1;
    chk(tag, RBUS, exp);
    RE   = 1'b0;
    ABUS = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    ABUS = addr;
    WBUS = data;
    WE   = 1'b1;
    step();
    WE   = 1'b0;
    WBUS = 16'h0000;
    ABUS = 16'h0000;
  endtask

  task automatic outs(input string tag, input logic req, input logic [3:0] num, input logic svc);
    chk({tag, "_intreq"}, {15'b0, INTREQ}, {15'b0, req});
    chk({tag, "_intnum"}, {12'b0, INTNUM}, {12'b0, num});
    chk({tag, "_insvc"},  {15'b0, INSVC},  {15'b0, svc});
  endtask

  initial begin
    INIT_N = 1'b0; ABUS = 16'h0; RE = 1'b0; WBUS = 16'h0; WE = 1'b0;
    IRQ = 3'b000; IE = 1'b0; INTACK = 1'b0; RETI = 1'b0;
    step(); step();
    INIT_N = 1'b1;
    step();

    outs("reset", 1'b0, 4'hF, 1'b0);
    rd(MADDR, 16'h0007, "reset_mask");
    rd(PADDR, 16'h0000, "reset_pend");

    // Single request from keys
    IE = 1'b1; IRQ = 3'b010;
    step();
    outs("single_e1", 1'b0, 4'hF, 1'b0);
    rd(PADDR, 16'h0002, "single_pend_set");
    step();
    outs("single_req", 1'b1, 4'd2, 1'b0);
    INTACK = 1'b1; step(); INTACK = 1'b0;
    outs("single_ack", 1'b0, 4'hF, 1'b1);
    rd(PADDR, 16'h0000, "single_pend_clr");
    RETI = 1'b1; step(); RETI = 1'b0;
    outs("single_reti", 1'b0, 4'hF, 1'b0);
    IRQ = 3'b000; step();

    // Priority: timer and switches together
    IRQ = 3'b101; step(); step();
    outs("prio_req1", 1'b1, 4'd1, 1'b0);
    INTACK = 1'b1; step(); INTACK = 1'b0;
    outs("prio_ack1", 1'b0, 4'hF, 1'b1);
    rd(PADDR, 16'h0004, "prio_pend_left");
    RETI = 1'b1; step(); RETI = 1'b0;
    outs("prio_idle_gap", 1'b0, 4'hF, 1'b0);
    step();
    outs("prio_req2", 1'b1, 4'd3, 1'b0);
    INTACK = 1'b1; step(); INTACK = 1'b0;
    RETI = 1'b1; step(); RETI = 1'b0;
    IRQ = 3'b000; step();
    outs("prio_done", 1'b0, 4'hF, 1'b0);

    // Mask and withdraw
    wr(MADDR, 16'h0006);
    rd(MADDR, 16'h0006, "mask_rd");
    IRQ = 3'b001; step(); step(); step();
    outs("masked", 1'b0, 4'hF, 1'b0);
    rd(PADDR, 16'h0001, "masked_pend");
    wr(MADDR, 16'h0007);
    outs("unmask_e1", 1'b0, 4'hF, 1'b0);
    step();
    outs("unmask_req", 1'b1, 4'd1, 1'b0);
    IE = 1'b0; step();
    outs("withdraw_ie", 1'b0, 4'hF, 1'b0);
    rd(PADDR, 16'h0001, "withdraw_pend_kept");
    wr(PADDR, 16'h0001);
    rd(PADDR, 16'h0000, "w1c_pend");
    IE = 1'b1; IRQ = 3'b000; step();

    // Collisions
    wr(MADDR, 16'h0000);
    IRQ = 3'b010; step();
    rd(PADDR, 16'h0002, "col_pend_set");
    IRQ = 3'b000; step();
    IRQ = 3'b010;
    wr(PADDR, 16'h0002);
    rd(PADDR, 16'h0002, "col_set_wins");
    wr(PADDR, 16'h0002);
    rd(PADDR, 16'h0000, "col_held_clr");
    step(); step();
    rd(PADDR, 16'h0000, "col_held_once");
    RETI = 1'b1; step(); RETI = 1'b0;
    outs("reti_idle", 1'b0, 4'hF, 1'b0);
    IRQ = 3'b000; step();

    // Async reset while requesting
    wr(MADDR, 16'h0007);
    IRQ = 3'b100; step(); step();
    outs("pre_reset_req", 1'b1, 4'd3, 1'b0);
    #2;
    INIT_N = 1'b0;
    #1;
    outs("async_reset", 1'b0, 4'hF, 1'b0);
    rd(MADDR, 16'h0007, "async_reset_mask");
    rd(PADDR, 16'h0000, "async_reset_pend");
    IRQ = 3'b000;
    step();
    INIT_N = 1'b1;
    step();
    outs("post_reset", 1'b0, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
